// File: rtl/simple_axi_cmd_queue.sv
// simple_axi_cmd_queue
//   Command sequencer in front of simple_axi_master. Commands are buffered in
//   a FIFO and issued one at a time on the master's rw/wait/done/clear
//   control interface. Each command produces exactly one response (rw, read
//   data, error, invalid), which is returned through a response FIFO.
//
// Parameters
//   CMD_DEPTH  command FIFO entries (power of 2, >= 2)
//   RSP_DEPTH  response FIFO entries (power of 2, >= 2)
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready       command handshake
//   i_cmd_rw/size/addr/wdata      command fields (rw: 00 idle, 01 write,
//                                 10 read, 11 reserved)
//   o_rsp_valid/i_rsp_ready       response handshake
//   o_rsp_rw/rdata/error/invalid  response fields (head of response FIFO)
//   o_m_rw/size/addr/wdata        to master i_rw/i_size/i_addr/i_wdata
//   i_m_wait/done/error/invalid   from master status
//   i_m_rdata                     from master read data
//   o_m_clear                     to master i_clear
//   o_busy                        FSM active or commands queued
//   o_halted/i_resume             halt-on-error control
//
// Build option
//   SIMPLE_AXI_CMD_QUEUE_HALT_ON_ERROR_EN: when defined, a response with
//   error=1 parks the FSM in S_HALT until i_resume. When undefined, o_halted
//   is tied low and i_resume is ignored.

module simple_axi_cmd_queue #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_rw,
  input  logic [2:0]  i_cmd_size,
  input  logic [31:0] i_cmd_addr,
  input  logic [63:0] i_cmd_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [1:0]  o_rsp_rw,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_error,
  output logic        o_rsp_invalid,
  output logic [1:0]  o_m_rw,
  output logic [2:0]  o_m_size,
  output logic [31:0] o_m_addr,
  output logic [63:0] o_m_wdata,
  input  logic        i_m_wait,
  input  logic        i_m_done,
  input  logic        i_m_error,
  input  logic        i_m_invalid,
  input  logic [63:0] i_m_rdata,
  output logic        o_m_clear,
  output logic        o_busy,
  output logic        o_halted,
  input  logic        i_resume
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam logic [CAW:0] CMD_FULL_CNT = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW:0] RSP_FULL_CNT = (RAW+1)'(RSP_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR, S_HALT} state_t;

  state_t state_reg, state_next;

  // ---------------- command FIFO: {rw, size, addr, wdata} ----------------
  logic [100:0]   cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr_reg, cmd_rd_ptr_reg;
  logic [CAW:0]   cmd_count_reg;
  logic           cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [100:0]   cmd_head;
  logic [1:0]     head_rw;

  assign cmd_full  = (cmd_count_reg == CMD_FULL_CNT);
  assign cmd_empty = (cmd_count_reg == '0);
  assign cmd_push  = i_cmd_valid && !cmd_full;
  assign cmd_head  = cmd_mem[cmd_rd_ptr_reg];
  assign head_rw   = cmd_head[100:99];

  always_ff @(posedge i_clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr_reg] <= {i_cmd_rw, i_cmd_size, i_cmd_addr, i_cmd_wdata};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cmd_wr_ptr_reg <= '0;
      cmd_rd_ptr_reg <= '0;
      cmd_count_reg  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + CAW'(1);
      if (cmd_pop)  cmd_rd_ptr_reg <= cmd_rd_ptr_reg + CAW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count_reg <= cmd_count_reg + (CAW+1)'(1);
        2'b01:   cmd_count_reg <= cmd_count_reg - (CAW+1)'(1);
        default: cmd_count_reg <= cmd_count_reg;
      endcase
    end
  end

  // ---------------- response FIFO: {rw, rdata, error, invalid} ----------------
  logic [67:0]    rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr_reg, rsp_rd_ptr_reg;
  logic [RAW:0]   rsp_count_reg;
  logic           rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [67:0]    rsp_push_data, rsp_head;

  assign rsp_full  = (rsp_count_reg == RSP_FULL_CNT);
  assign rsp_empty = (rsp_count_reg == '0);
  assign rsp_pop   = !rsp_empty && i_rsp_ready;
  // Masked while empty so stale or uninitialised entries never reach the outputs.
  assign rsp_head  = rsp_empty ? '0 : rsp_mem[rsp_rd_ptr_reg];

  always_ff @(posedge i_clk) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr_reg] <= rsp_push_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_wr_ptr_reg <= '0;
      rsp_rd_ptr_reg <= '0;
      rsp_count_reg  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr_reg <= rsp_wr_ptr_reg + RAW'(1);
      if (rsp_pop)  rsp_rd_ptr_reg <= rsp_rd_ptr_reg + RAW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count_reg <= rsp_count_reg + (RAW+1)'(1);
        2'b01:   rsp_count_reg <= rsp_count_reg - (RAW+1)'(1);
        default: rsp_count_reg <= rsp_count_reg;
      endcase
    end
  end

  // ---------------- sequencer FSM ----------------
  logic [1:0]  cur_rw_reg;
  logic [1:0]  m_rw_reg;
  logic [2:0]  m_size_reg;
  logic [31:0] m_addr_reg;
  logic [63:0] m_wdata_reg;
  logic        m_clear_reg;

`ifdef SIMPLE_AXI_CMD_QUEUE_HALT_ON_ERROR_EN
  // Error flag of the most recent master response; consulted in S_CLEAR.
  logic halt_pending_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         halt_pending_reg <= 1'b0;
    else if (rsp_push) halt_pending_reg <= rsp_push_data[1];
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    cmd_pop       = 1'b0;
    rsp_push      = 1'b0;
    rsp_push_data = '0;
    case (state_reg)
      S_IDLE: begin
        // Waiting for a free response slot guarantees the issued command can
        // always deliver its response later.
        if (!cmd_empty && !rsp_full) begin
          if (head_rw == 2'b01 || head_rw == 2'b10) begin
            state_next = S_ISSUE;
          end else begin
            cmd_pop       = 1'b1;
            rsp_push      = 1'b1;
            rsp_push_data = {head_rw, 64'd0, 1'b1, 1'b1};
`ifdef SIMPLE_AXI_CMD_QUEUE_HALT_ON_ERROR_EN
            state_next    = S_HALT;
`endif
          end
        end
      end
      S_ISSUE: begin
        cmd_pop = 1'b1;
        // Done in the issue cycle means the master rejected the request.
        if (i_m_done) begin
          rsp_push      = 1'b1;
          rsp_push_data = {cur_rw_reg, 64'd0, i_m_error, i_m_invalid};
          state_next    = S_CLEAR;
        end else begin
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_m_done) begin
          rsp_push      = 1'b1;
          rsp_push_data = {cur_rw_reg, (cur_rw_reg == 2'b10) ? i_m_rdata : 64'd0,
                           i_m_error, i_m_invalid};
          state_next    = S_CLEAR;
        end
      end
      S_CLEAR: begin
`ifdef SIMPLE_AXI_CMD_QUEUE_HALT_ON_ERROR_EN
        state_next = halt_pending_reg ? S_HALT : S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      S_HALT: begin
`ifdef SIMPLE_AXI_CMD_QUEUE_HALT_ON_ERROR_EN
        if (i_resume) state_next = S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Master-side outputs are registered off the next state so they line up
  // with the state they belong to; size/addr/wdata hold between issues.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cur_rw_reg  <= 2'b00;
      m_rw_reg    <= 2'b00;
      m_size_reg  <= '0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      m_clear_reg <= 1'b0;
    end else begin
      m_rw_reg    <= 2'b00;
      m_clear_reg <= (state_next == S_CLEAR);
      if (state_next == S_ISSUE) begin
        cur_rw_reg  <= head_rw;
        m_rw_reg    <= head_rw;
        m_size_reg  <= cmd_head[98:96];
        m_addr_reg  <= cmd_head[95:64];
        m_wdata_reg <= cmd_head[63:0];
      end
    end
  end

  // The master must be quiet whenever it is not being driven or awaited.
  assert property (@(posedge i_clk) disable iff (i_rst)
    ((state_reg == S_IDLE) || (state_reg == S_CLEAR)) |-> !i_m_wait);

  // ---------------- outputs ----------------
  assign o_cmd_ready   = !cmd_full;
  assign o_rsp_valid   = !rsp_empty;
  assign o_rsp_rw      = rsp_head[67:66];
  assign o_rsp_rdata   = rsp_head[65:2];
  assign o_rsp_error   = rsp_head[1];
  assign o_rsp_invalid = rsp_head[0];
  assign o_m_rw        = m_rw_reg;
  assign o_m_size      = m_size_reg;
  assign o_m_addr      = m_addr_reg;
  assign o_m_wdata     = m_wdata_reg;
  assign o_m_clear     = m_clear_reg;
  assign o_busy        = (state_reg != S_IDLE) || !cmd_empty;

`ifdef SIMPLE_AXI_CMD_QUEUE_HALT_ON_ERROR_EN
  assign o_halted = (state_reg == S_HALT);
`else
  logic unused_resume;
  assign unused_resume = i_resume;
  assign o_halted      = 1'b0;
`endif

endmodule
